// File: rtl/result_writer_bram_if.sv
// Bundle for result_writer_bram: the start/status signals, the vector handshake and the BRAM port.
// Valid/ready: a vector transfers on a rising edge where i_valid && o_ready; the source holds i_result while i_valid is up.
interface result_writer_bram_if #(
  parameter int CNT_BIT  = 31,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12,
  parameter int NUM_LANE = 8
);
  logic                       i_run;
  logic [CNT_BIT-1:0]         i_num_cnt;
  logic [AWIDTH-1:0]          i_base_addr;
  logic                       i_valid;
  logic [NUM_LANE*DWIDTH-1:0] i_result;
  logic                       o_ready;
  logic                       o_idle;
  logic                       o_write;
  logic                       o_done;
  logic [AWIDTH-1:0]          addr_b;
  logic                       ce_b;
  logic                       we_b;
  logic [DWIDTH-1:0]          d_b;
  logic [DWIDTH-1:0]          q_b;

  modport master (
    output i_run, i_num_cnt, i_base_addr, i_valid, i_result, q_b,
    input  o_ready, o_idle, o_write, o_done, addr_b, ce_b, we_b, d_b
  );

  modport slave (
    input  i_run, i_num_cnt, i_base_addr, i_valid, i_result, q_b,
    output o_ready, o_idle, o_write, o_done, addr_b, ce_b, we_b, d_b
  );
endinterface

// File: rtl/result_writer_bram.sv
// Buffers one NUM_LANE-word result vector and writes its lanes to a single-port BRAM, one word per cycle.
// Optional macro RESULT_WRITER_RELU_EN: zero every negative lane on its way to the BRAM.
module result_writer_bram #(
  parameter int CNT_BIT  = 31,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12,
  parameter int NUM_LANE = 8
) (
  input  logic               clk,
  input  logic               reset,
  result_writer_bram_if.slave bus,
  output logic [1:0]         dbg_state
);
  localparam int LANE_BIT = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam logic [LANE_BIT-1:0] LANE_LAST = LANE_BIT'(NUM_LANE - 1);
  localparam logic [CNT_BIT-1:0]  CNT_ONE   = CNT_BIT'(1);
  localparam logic [AWIDTH-1:0]   ADDR_ONE  = AWIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [CNT_BIT-1:0]  num_cnt;
  logic [CNT_BIT-1:0]  vec_cnt;
  logic [LANE_BIT-1:0] lane_cnt;
  logic [AWIDTH-1:0]   wr_addr;
  logic [DWIDTH-1:0]   buf_q [NUM_LANE];
  logic [DWIDTH-1:0]   lane_raw;
  logic [DWIDTH-1:0]   lane_out;
  logic                last_lane;
  logic                last_vec;
  logic                unused_q;

  assign unused_q  = ^bus.q_b;
  assign dbg_state = state;
  assign last_lane = (lane_cnt == LANE_LAST);
  assign last_vec  = (vec_cnt == num_cnt - CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.i_run) state_nx = (bus.i_num_cnt != '0) ? S_FILL : S_DONE;
      S_FILL:  if (bus.i_valid) state_nx = S_WRITE;
      S_WRITE: if (last_lane) state_nx = last_vec ? S_DONE : S_FILL;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // wr_addr walks base + vec*NUM_LANE + lane incrementally; AWIDTH overflow gives the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_cnt  <= '0;
      vec_cnt  <= '0;
      lane_cnt <= '0;
      wr_addr  <= '0;
      for (int k = 0; k < NUM_LANE; k++) buf_q[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_run) begin
            num_cnt  <= bus.i_num_cnt;
            wr_addr  <= bus.i_base_addr;
            vec_cnt  <= '0;
            lane_cnt <= '0;
          end
        end
        S_FILL: begin
          if (bus.i_valid) begin
            for (int k = 0; k < NUM_LANE; k++) buf_q[k] <= bus.i_result[k*DWIDTH +: DWIDTH];
          end
        end
        S_WRITE: begin
          wr_addr <= wr_addr + ADDR_ONE;
          if (last_lane) begin
            lane_cnt <= '0;
            vec_cnt  <= vec_cnt + CNT_ONE;
          end else begin
            lane_cnt <= lane_cnt + 1'b1;
          end
        end
        S_DONE:  num_cnt <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_raw = buf_q[lane_cnt];
`ifdef RESULT_WRITER_RELU_EN
    lane_out = lane_raw[DWIDTH-1] ? '0 : lane_raw;
`else
    lane_out = lane_raw;
`endif
  end

  always_comb begin
    bus.o_idle  = (state == S_IDLE);
    bus.o_ready = (state == S_FILL);
    bus.o_write = (state == S_WRITE);
    bus.o_done  = (state == S_DONE);
    bus.ce_b    = (state == S_WRITE);
    bus.we_b    = (state == S_WRITE);
    bus.addr_b  = '0;
    bus.d_b     = '0;
    if (state == S_WRITE) begin
      bus.addr_b = wr_addr;
      bus.d_b    = lane_out;
    end
  end
endmodule

// File: tb/tb_result_writer_bram.sv
// Self-checking bench for result_writer_bram: scenario tasks against a queue-based write model and BRAM array.
module tb_result_writer_bram;
  localparam int CNT_BIT = 31;
  localparam int DW      = 32;
  localparam int AW      = 12;
  localparam int NL      = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  result_writer_bram_if #(.CNT_BIT(CNT_BIT), .DWIDTH(DW), .AWIDTH(AW), .NUM_LANE(NL)) bus ();
  logic [1:0] dbg_state;

  result_writer_bram #(.CNT_BIT(CNT_BIT), .DWIDTH(DW), .AWIDTH(AW), .NUM_LANE(NL)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int bad_bus_cnt = 0;

  logic [AW-1:0] obs_addr_q[$];
  logic [DW-1:0] obs_data_q[$];
  int            obs_cyc_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  int            acc_cyc_q[$];
  logic [DW-1:0] mem [1<<AW];

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model and bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_done) done_cnt++;
      if (bus.ce_b !== bus.o_write || bus.we_b !== bus.o_write) bad_bus_cnt++;
      if (!bus.o_write && (bus.addr_b !== '0 || bus.d_b !== '0)) bad_bus_cnt++;
      if (bus.o_write && bus.o_ready) overlap_cnt++;
      if (bus.ce_b && bus.we_b) begin
        obs_addr_q.push_back(bus.addr_b);
        obs_data_q.push_back(bus.d_b);
        obs_cyc_q.push_back(cyc);
        mem[bus.addr_b] = bus.d_b;
      end
    end
  end

  function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] x);
`ifdef RESULT_WRITER_RELU_EN
    if ($signed(x) < 0) return '0;
`endif
    return x;
  endfunction

  // driver + scoreboard: mode 0 random lanes, 1 lane=index+1, 2 ReLU pattern
  task automatic run_job(input logic [AW-1:0] base, input int n, input int mode,
                         input bit hold, input bit noisy);
    logic [NL*DW-1:0] vec;
    logic [DW-1:0]    lane;
    bit ok;
    int run_c, done_c, done_before, exp_c, nmin;
    obs_addr_q.delete(); obs_data_q.delete(); obs_cyc_q.delete();
    exp_addr_q.delete(); exp_q.delete(); acc_cyc_q.delete();
    done_before = done_cnt;
    done_c = -1;
    @(posedge clk); #1;
    bus.i_num_cnt = CNT_BIT'(n); bus.i_base_addr = base; bus.i_run = 1'b1;
    @(posedge clk); #1;
    bus.i_run = 1'b0;
    run_c = cyc;
    if (n > 0) begin
      @(negedge clk);
      checks++;
      if (bus.o_ready !== 1'b1) begin
        errors++; $display("FAIL ready_after_run: got %b expected 1", bus.o_ready);
      end
      @(posedge clk); #1;
    end
    for (int v = 0; v < n; v++) begin
      for (int k = 0; k < NL; k++) begin
        case (mode)
          1:       lane = DW'(v*NL + k + 1);
          2:       lane = (k == 0) ? 32'hFFFF_FFF0 : (k == 1) ? 32'h0000_0005 : DW'($urandom);
          default: lane = DW'($urandom);
        endcase
        vec[k*DW +: DW] = lane;
        exp_addr_q.push_back(base + AW'(v*NL + k));
        exp_q.push_back(relu_model(lane));
      end
      if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      bus.i_result = vec;
      bus.i_valid  = 1'b1;
      if (noisy) begin
        bus.i_run = 1'b1;
        bus.i_num_cnt = CNT_BIT'($urandom_range(0, 5));
        bus.i_base_addr = AW'($urandom);
      end
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.o_ready) ok = 1'b1;
        @(posedge clk); #1;
        if (ok) break;
      end
      checks++;
      if (!ok) begin
        errors++; $display("FAIL accept_timeout: vector %0d got no ready expected ready", v);
        bus.i_valid = 1'b0; bus.i_run = 1'b0;
        return;
      end
      acc_cyc_q.push_back(cyc);
      bus.i_run = 1'b0;
      if (noisy) begin
        bus.i_result = {NL{DW'($urandom)}};
        repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
        bus.i_valid = 1'b0;
      end else if (!hold) begin
        bus.i_valid = 1'b0;
      end
    end
    bus.i_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.o_done) begin ok = 1'b1; done_c = cyc; break; end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL done_timeout: got no o_done expected o_done");
    end else begin
      exp_c = (n == 0) ? run_c : acc_cyc_q[acc_cyc_q.size()-1] + NL;
      checks++;
      if (done_c !== exp_c) begin
        errors++; $display("FAIL done_cycle: got %0d expected %0d", done_c, exp_c);
      end
      @(negedge clk);
      checks++;
      if ({bus.o_idle, bus.o_done} !== 2'b10) begin
        errors++; $display("FAIL idle_after_done: got idle,done=%b expected 10", {bus.o_idle, bus.o_done});
      end
    end
    checks++;
    if (done_cnt - done_before !== 1) begin
      errors++; $display("FAIL done_pulses: got %0d expected 1", done_cnt - done_before);
    end
    checks++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin
      errors++; $display("FAIL write_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size());
    end
    nmin = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < nmin; i++) begin
      checks++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL write_%0d: got addr %h data %h expected addr %h data %h",
                 i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_q[i]);
      end
      exp_c = acc_cyc_q[i/NL] + (i % NL);
      checks++;
      if (obs_cyc_q[i] !== exp_c) begin
        errors++; $display("FAIL write_cycle_%0d: got %0d expected %0d", i, obs_cyc_q[i], exp_c);
      end
    end
    checks++;
    if (overlap_cnt !== 0 || bad_bus_cnt !== 0) begin
      errors++; $display("FAIL bus_rules: got overlap %0d bad_bus %0d expected 0 0", overlap_cnt, bad_bus_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.o_idle, bus.o_ready, bus.o_write, bus.o_done, bus.ce_b, bus.we_b} !== 6'b100000) begin
      errors++; $display("FAIL reset_flags: got %b expected 100000",
        {bus.o_idle, bus.o_ready, bus.o_write, bus.o_done, bus.ce_b, bus.we_b});
    end
    checks++;
    if (bus.addr_b !== '0 || bus.d_b !== '0) begin
      errors++; $display("FAIL reset_bus: got addr %h data %h expected 0 0", bus.addr_b, bus.d_b);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_idle, bus.o_ready, bus.o_write} !== 3'b100) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 100", {bus.o_idle, bus.o_ready, bus.o_write});
    end
  endtask

  task automatic test_single();
    run_job(12'h010, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job(AW'($urandom), 3, 0, 1'b1, 1'b0);
    for (int i = 1; i < acc_cyc_q.size(); i++) begin
      checks++;
      if (acc_cyc_q[i] - acc_cyc_q[i-1] !== NL + 1) begin
        errors++; $display("FAIL throughput_%0d: got %0d expected %0d", i, acc_cyc_q[i] - acc_cyc_q[i-1], NL + 1);
      end
    end
  endtask

  task automatic test_wrap();
    run_job(12'hFFC, 1, 1, 1'b0, 1'b0);
    checks++;
    if (mem[12'h003] !== 32'd8 || mem[12'hFFC] !== 32'd1) begin
      errors++; $display("FAIL wrap_mem: got %h %h expected 00000001 00000008", mem[12'hFFC], mem[12'h003]);
    end
  endtask

  task automatic test_zero();
    run_job(AW'($urandom), 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(posedge clk); #1;
    bus.i_num_cnt = CNT_BIT'(2); bus.i_base_addr = 12'h100; bus.i_run = 1'b1;
    @(posedge clk); #1;
    bus.i_run = 1'b0;
    bus.i_result = {NL{DW'($urandom)}};
    bus.i_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.o_write && bus.addr_b == 12'h103) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL lane3_timeout: got no lane-3 write expected one");
    end
    #1; reset = 1'b1; bus.i_valid = 1'b0;
    #1;
    checks++;
    if ({bus.o_idle, bus.o_ready, bus.o_write, bus.o_done, bus.ce_b, bus.we_b} !== 6'b100000) begin
      errors++; $display("FAIL midreset_flags: got %b expected 100000",
        {bus.o_idle, bus.o_ready, bus.o_write, bus.o_done, bus.ce_b, bus.we_b});
    end
    checks++;
    if (bus.addr_b !== '0 || bus.d_b !== '0) begin
      errors++; $display("FAIL midreset_bus: got addr %h data %h expected 0 0", bus.addr_b, bus.d_b);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_job(12'h100, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_relu();
    run_job(12'h200, 1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++)
      run_job(AW'($urandom), $urandom_range(1, 4), 0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  initial begin
    bus.i_run = 1'b0; bus.i_num_cnt = '0; bus.i_base_addr = '0;
    bus.i_valid = 1'b0; bus.i_result = '0; bus.q_b = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_relu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
